intt_512_point: RTL and testbench

//  Inverse NTT over Z_q, N=512, q=7681. Restores coefficients from NTT-domain vectors produced by the forward 512-point NTT.

---
 rtl/ntt_pkg.sv | 35 +++
 rtl/mod_mul_q.sv | 17 +
 rtl/intt_512_point.sv | 105 ++++++++++
 tb/tb_intt_512_point.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Constants and FSM state encoding shared by the forward and inverse 512-point NTT over Z_7681.
package ntt_pkg;

  localparam int N          = 512;
  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 9;
  localparam int MODULUS    = 7681;
  localparam int ROOT       = 7146;
  localparam int ROOT_INV   = 7480;
  localparam int N_INV      = 7666;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_SCALE = 2'd2,
    ST_DONE  = 2'd3
  } ntt_state_e;

  // Elaboration-time base^e mod MODULUS, used to derive twiddles for shorter transforms.
  function automatic int mod_pow(input int base, input int e_in);
    int r;
    int b;
    int e;
    r = 1;
    b = base % MODULUS;
    e = e_in;
    while (e > 0) begin
      if ((e % 2) == 1) r = (r * b) % MODULUS;
      b = (b * b) % MODULUS;
      e = e / 2;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_mul_q.sv
// Combinational modular multiplier: p = a*b mod MODULUS, reduced in the same cycle.
module mod_mul_q
  import ntt_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] p_o
);

  logic [2*DATA_WIDTH-1:0] prod;
  logic [2*DATA_WIDTH-1:0] rem;

  assign prod = (2*DATA_WIDTH)'(a_i) * (2*DATA_WIDTH)'(b_i);
  assign rem  = prod % (2*DATA_WIDTH)'(MODULUS);
  assign p_o  = rem[DATA_WIDTH-1:0];

endmodule

// File: rtl/intt_512_point.sv
// Sequential direct-form inverse NTT: one modular MAC per cycle, then a 1/N scale per output point.
module intt_512_point #(
  parameter int N          = ntt_pkg::N,
  parameter int ADDR_WIDTH = $clog2(N),
  parameter int ROOT_INV   = ntt_pkg::mod_pow(ntt_pkg::ROOT_INV, ntt_pkg::N / N),
  parameter int N_INV      = ntt_pkg::mod_pow(N % ntt_pkg::MODULUS, ntt_pkg::MODULUS - 2)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  input  logic [N*ntt_pkg::DATA_WIDTH-1:0]    data_in,
  output logic [N*ntt_pkg::DATA_WIDTH-1:0]    data_out,
  output logic [1:0]                          dbg_state_o
);

  localparam int DW = ntt_pkg::DATA_WIDTH;
  localparam logic [DW-1:0]         Q       = DW'(ntt_pkg::MODULUS);
  localparam logic [DW-1:0]         W_STEP  = DW'(ROOT_INV);
  localparam logic [DW-1:0]         SCALE_F = DW'(N_INV);
  localparam logic [DW-1:0]         ONE     = DW'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(N - 1);

  ntt_pkg::ntt_state_e state_q, state_d;

  logic [DW-1:0]         vec_q [N];
  logic [DW-1:0]         w_n_q, w_nk_q, acc_q;
  logic [ADDR_WIDTH-1:0] k_q, n_q;
  logic [N*DW-1:0]       data_out_q;

  logic [DW-1:0] term, tw_b, tw_prod, scaled, acc_sum, acc_next;

  mod_mul_q u_mul_term  (.a_i(vec_q[k_q]), .b_i(w_nk_q),  .p_o(term));
  mod_mul_q u_mul_tw    (.a_i(w_n_q),      .b_i(tw_b),    .p_o(tw_prod));
  mod_mul_q u_mul_scale (.a_i(acc_q),      .b_i(SCALE_F), .p_o(scaled));

  // The twiddle multiplier steps w_nk by w_n during MAC and w_n by ROOT_INV during SCALE.
  assign tw_b     = (state_q == ntt_pkg::ST_SCALE) ? W_STEP : w_nk_q;
  assign acc_sum  = acc_q + term;
  assign acc_next = (acc_sum >= Q) ? (acc_sum - Q) : acc_sum;

  // Handshake: start is a one-cycle request honoured only in IDLE; busy is high for
  // MAC/SCALE; done pulses for the single DONE cycle with busy low; any other start is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ntt_pkg::ST_IDLE:  if (start) state_d = ntt_pkg::ST_MAC;
      ntt_pkg::ST_MAC:   if (k_q == LAST) state_d = ntt_pkg::ST_SCALE;
      ntt_pkg::ST_SCALE: state_d = (n_q == LAST) ? ntt_pkg::ST_DONE : ntt_pkg::ST_MAC;
      ntt_pkg::ST_DONE:  state_d = ntt_pkg::ST_IDLE;
      default:           state_d = ntt_pkg::ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ntt_pkg::ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) vec_q[i] <= '0;
      w_n_q      <= '0;
      w_nk_q     <= '0;
      acc_q      <= '0;
      k_q        <= '0;
      n_q        <= '0;
      data_out_q <= '0;
    end else begin
      case (state_q)
        ntt_pkg::ST_IDLE: begin
          if (start) begin
            for (int i = 0; i < N; i++) vec_q[i] <= data_in[i*DW +: DW] % Q;
            w_n_q  <= ONE;
            w_nk_q <= ONE;
            acc_q  <= '0;
            k_q    <= '0;
            n_q    <= '0;
          end
        end
        ntt_pkg::ST_MAC: begin
          acc_q  <= acc_next;
          w_nk_q <= tw_prod;
          k_q    <= (k_q == LAST) ? '0 : k_q + ADDR_WIDTH'(1);
        end
        ntt_pkg::ST_SCALE: begin
          data_out_q[n_q*DW +: DW] <= scaled;
          w_n_q  <= tw_prod;
          w_nk_q <= ONE;
          acc_q  <= '0;
          k_q    <= '0;
          if (n_q != LAST) n_q <= n_q + ADDR_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state_q == ntt_pkg::ST_MAC) || (state_q == ntt_pkg::ST_SCALE);
  assign done        = (state_q == ntt_pkg::ST_DONE);
  assign data_out    = data_out_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_intt_512_point.sv
// Bench for intt_512_point, elaborated as a 16-point transform so every run stays short.
module tb_intt_512_point;
  import ntt_pkg::*;

  localparam int NT    = 16;
  localparam int AW    = 4;
  localparam int DW    = DATA_WIDTH;
  localparam int Q     = MODULUS;
  localparam int LAT   = NT * (NT + 1) + 1;
  localparam int LIMIT = LAT + 50;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            busy;
  logic            done;
  logic [NT*DW-1:0] data_in;
  logic [NT*DW-1:0] data_out;
  logic [1:0]      dbg_state;

  logic [DW-1:0] x_in  [NT];
  logic [DW-1:0] x_exp [NT];
  logic [DW-1:0] exp_q [$];
  longint        root_f, root_i, ninv;
  int            n_vec, n_err;

  intt_512_point #(.N(NT), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .data_in(data_in), .data_out(data_out), .dbg_state_o(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic longint mpow(input longint b, input longint e);
    longint r, bb, ee;
    r = 1; bb = b % Q; ee = e;
    while (ee > 0) begin
      if ((ee % 2) == 1) r = (r * bb) % Q;
      bb = (bb * bb) % Q;
      ee = ee / 2;
    end
    return r;
  endfunction

  // Direct inverse transform of x_in into x_exp.
  task automatic model_inverse();
    longint acc;
    for (int n = 0; n < NT; n++) begin
      acc = 0;
      for (int k = 0; k < NT; k++)
        acc = (acc + (longint'(x_in[k]) % Q) * mpow(root_i, n * k)) % Q;
      x_exp[n] = DW'((acc * ninv) % Q);
    end
  endtask

  task automatic run_vector(input string name, input bit noisy, input bit start_at_done);
    int            cyc;
    logic [DW-1:0] exp_v;
    logic [DW-1:0] got;
    for (int n = 0; n < NT; n++) exp_q.push_back(x_exp[n]);
    @(negedge clk);
    for (int k = 0; k < NT; k++) data_in[k*DW +: DW] = x_in[k];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < NT; k++) data_in[k*DW +: DW] = DW'($urandom);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
    end
    cyc = 0;
    while (done !== 1'b1 && cyc < LIMIT) begin
      start = noisy ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start = start_at_done;
    n_vec++;
    if (done !== 1'b1) begin
      n_err++; $display("FAIL %s done_timeout: no done after %0d cycles, expected %0d", name, cyc, LAT);
      start = 1'b0;
      exp_q.delete();
      return;
    end
    // done becomes visible after edge cyc; the edge that samples it is one later.
    n_vec++;
    if (cyc + 1 !== LAT) begin
      n_err++; $display("FAIL %s latency: got %0d expected %0d", name, cyc + 1, LAT);
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL %s busy_in_done: got %b expected 0", name, busy);
    end
    @(posedge clk); #1;
    start = 1'b0;
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_err++; $display("FAIL %s after_done: done=%b busy=%b state=%0d expected 0 0 0", name, done, busy, dbg_state);
    end
    for (int n = 0; n < NT; n++) begin
      exp_v = exp_q.pop_front();
      got   = data_out[n*DW +: DW];
      n_vec++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL %s x[%0d]: got %0d expected %0d", name, n, got, exp_v);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_err++; $display("FAIL reset_ctrl: busy=%b done=%b state=%0d expected 0 0 0", busy, done, dbg_state);
    end
    n_vec++;
    if (data_out !== '0) begin
      n_err++; $display("FAIL reset_data_out: got %h expected 0", data_out);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_err++; $display("FAIL idle_after_reset: busy=%b state=%0d expected 0 0", busy, dbg_state);
    end
  endtask

  task automatic test_all_ones();
    for (int k = 0; k < NT; k++) x_in[k] = DW'(1);
    for (int n = 0; n < NT; n++) x_exp[n] = (n == 0) ? DW'(1) : DW'(0);
    run_vector("all_ones", 1'b0, 1'b0);
  endtask

  task automatic test_impulse0();
    for (int k = 0; k < NT; k++) x_in[k] = (k == 0) ? DW'(1) : DW'(0);
    for (int n = 0; n < NT; n++) x_exp[n] = DW'(ninv);
    run_vector("impulse0", 1'b0, 1'b0);
  endtask

  task automatic test_impulse1();
    for (int k = 0; k < NT; k++) x_in[k] = (k == 1) ? DW'(1) : DW'(0);
    for (int n = 0; n < NT; n++) x_exp[n] = DW'((ninv * mpow(root_i, n)) % Q);
    run_vector("impulse1", 1'b0, 1'b0);
  endtask

  task automatic test_round_trip();
    longint acc;
    for (int v = 0; v < 20; v++) begin
      for (int n = 0; n < NT; n++) x_exp[n] = DW'($urandom_range(0, Q - 1));
      for (int k = 0; k < NT; k++) begin
        acc = 0;
        for (int n = 0; n < NT; n++)
          acc = (acc + longint'(x_exp[n]) * mpow(root_f, n * k)) % Q;
        x_in[k] = DW'(acc);
      end
      run_vector($sformatf("round_trip%0d", v), 1'b0, 1'b0);
    end
  endtask

  task automatic test_overrange_busy_start();
    for (int k = 0; k < NT; k++) x_in[k] = 16'hFFFF;
    for (int n = 0; n < NT; n++) x_exp[n] = (n == 0) ? DW'(65535 % Q) : DW'(0);
    run_vector("overrange_busy_start", 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    int dones;
    for (int k = 0; k < NT; k++) x_in[k] = DW'($urandom);
    @(negedge clk);
    for (int k = 0; k < NT; k++) data_in[k*DW +: DW] = x_in[k];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (100) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || dbg_state !== ST_IDLE || data_out !== '0) begin
      n_err++; $display("FAIL mid_run_reset: busy=%b done=%b state=%0d data_out=%h expected all 0", busy, done, dbg_state, data_out);
    end
    dones = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    n_vec++;
    if (dones !== 0) begin
      n_err++; $display("FAIL mid_run_no_done: got %0d done pulses expected 0", dones);
    end
    model_inverse();
    run_vector("after_mid_run_reset", 1'b0, 1'b0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; data_in = '0;
    root_f = mpow(ROOT, N / NT);
    root_i = mpow(root_f, NT - 1);
    ninv   = Q - (Q - 1) / NT;
    test_reset();
    test_all_ones();
    test_impulse0();
    test_impulse1();
    test_round_trip();
    test_overrange_busy_start();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
